sha_job_ctrl: RTL

Sequencer for one `sha512` core.
- Accepts a message as 1024-bit blocks, delivered as 32-bit words over a valid/ready stream, and buffers each full block.
- Drives the core's command/text interface to hash the block.
- After the last block, reads back the 512-bit digest and emits it as 16 words on a second valid/ready stream.
- Sits between a host/DMA word stream and a single `sha512` instance; a chained multi-core top instantiates one controller per core it exposes.

---
 rtl/sha_ctrl_pkg.sv | 30 +++
 rtl/sha_word_buf.sv | 24 ++
 rtl/sha_job_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the sha512 job controller.
// The controller and its word buffer both import this package.
package sha_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_PUSH,
        ST_WAIT,
        ST_RDCMD,
        ST_PULL,
        ST_DRAIN,
        ST_ERR
    } state_e;

    localparam logic [1:0] SHA_OP_WRITE = 2'b10;
    localparam logic [1:0] SHA_OP_READ  = 2'b01;
    localparam int         SHA_BUSY_BIT = 4;
    localparam int         BLK_WORDS    = 32;
    localparam int         DIG_WORDS    = 16;
    localparam int         IDX_W        = 5;
    localparam int         TMO_W        = 12;

    // Core command word: bit 3 reserved, bit 2 "first block", bits 1:0 opcode.
    function automatic logic [3:0] sha_cmd(input logic [1:0] op, input logic first);
        return {1'b0, first, op};
    endfunction

endpackage

// File: rtl/sha_word_buf.sv
// 32x32 register file: one synchronous write port, one asynchronous read port.
// Holds the message block while it is pushed and the digest while it drains.
module sha_word_buf
    import sha_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [BLK_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sha_job_ctrl.sv
// Sequences one sha512 core: buffers 1024-bit blocks from a word stream,
// pushes them to the core, and streams the 512-bit digest back out.
module sha_job_ctrl
    import sha_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic [31:0] blk_data_i,
    input  logic        blk_first_i,
    input  logic        blk_last_i,
    output logic        dig_valid_o,
    input  logic        dig_ready_i,
    output logic [31:0] dig_data_o,
    output logic        dig_last_o,
    output logic [31:0] sha_text_o,
    output logic [3:0]  sha_cmd_o,
    output logic        sha_cmd_w_o,
    input  logic [31:0] sha_text_i,
    input  logic [4:0]  sha_cmd_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               first_q, first_d;
    logic               last_q, last_d;

    logic               buf_we;
    logic [IDX_W-1:0]   buf_waddr;
    logic [31:0]        buf_wdata;
    logic [31:0]        buf_rdata;

    logic               ready_c, cmd_w_c, dvalid_c, dlast_c, busy_c, err_c;
    logic [3:0]         cmd_c;
    logic [31:0]        text_c, ddata_c;
    logic               unused_cmd_bits;

    assign unused_cmd_bits = ^sha_cmd_i[3:0];

    sha_word_buf u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (idx_q),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        first_d   = first_q;
        last_d    = last_q;
        buf_we    = 1'b0;
        buf_waddr = idx_q;
        buf_wdata = blk_data_i;
        ready_c   = 1'b0;
        cmd_w_c   = 1'b0;
        cmd_c     = 4'b0000;
        text_c    = 32'h0;
        dvalid_c  = 1'b0;
        dlast_c   = 1'b0;
        ddata_c   = 32'h0;
        busy_c    = (state_q != ST_IDLE);
        err_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (blk_valid_i) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    first_d   = blk_first_i;
                    last_d    = blk_last_i;
                    idx_d     = IDX_W'(1);
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                ready_c = 1'b1;
                if (blk_valid_i) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(BLK_WORDS - 1)) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cmd_w_c = 1'b1;
                cmd_c   = sha_cmd(SHA_OP_WRITE, first_q);
                idx_d   = '0;
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                text_c = buf_rdata;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BLK_WORDS - 1)) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            // The core raises busy a cycle late, so the first WAIT cycle never exits.
            ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_q != '0 && !sha_cmd_i[SHA_BUSY_BIT]) begin
                    state_d = last_q ? ST_RDCMD : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_RDCMD: begin
                cmd_w_c = 1'b1;
                cmd_c   = sha_cmd(SHA_OP_READ, 1'b0);
                idx_d   = '0;
                state_d = ST_PULL;
            end
            ST_PULL: begin
                buf_we    = 1'b1;
                buf_wdata = sha_text_i;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DIG_WORDS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dvalid_c = 1'b1;
                ddata_c  = buf_rdata;
                dlast_c  = (idx_q == IDX_W'(DIG_WORDS - 1));
                if (dig_ready_i) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (dlast_c) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                err_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Outputs are forced low while reset is held so no strobe escapes mid-block.
    assign blk_ready_o = rst_i ? 1'b0  : ready_c;
    assign sha_cmd_w_o = rst_i ? 1'b0  : cmd_w_c;
    assign sha_cmd_o   = rst_i ? 4'h0  : cmd_c;
    assign sha_text_o  = rst_i ? 32'h0 : text_c;
    assign dig_valid_o = rst_i ? 1'b0  : dvalid_c;
    assign dig_data_o  = rst_i ? 32'h0 : ddata_c;
    assign dig_last_o  = rst_i ? 1'b0  : dlast_c;
    assign busy_o      = rst_i ? 1'b0  : busy_c;
    assign err_o       = rst_i ? 1'b0  : err_c;

endmodule
